relu6_ram_reader: RTL and testbench
===================================

# relu6_ram_reader

Read-side sequencer for the layer-6 ReLU6 output buffer, a 16-entry × 512-bit memory with one-cycle registered read latency. On a start pulse, it reads every entry in address order. It buffers the read data in a 2-entry output FIFO and streams the entries to the next layer over a valid/ready interface, with full backpressure support. It owns the memory's read port (`rd_en`/`rd_addr`) exclusively.

## Interface
- `DEPTH`, 16: number of entries read per frame (4×4 feature map positions).
- `DATA_W`, 512: entry width in bits.
- `ADDR_W`, 7: address width.
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to stream one frame; ignored while `busy`=1.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the final beat handshakes.
- `rd_en`  out  1  memory read strobe (combinational).
- `rd_addr`  out  ADDR_W  memory read address (combinational).
- `rd_data`  in  DATA_W  memory output; valid in the cycle after the edge that sampled `rd_en`.
- `out_valid`  out  1  `out_data` holds a beat (FIFO head).
- `out_ready`  in  1  the consumer accepts the beat at this edge if `out_valid`=1.
- `out_data`  out  DATA_W  beat payload.
- `out_index`  out  ADDR_W  memory address the beat came from.
- `out_last`  out  1  high with the beat whose `out_index`=DEPTH-1.

## Operation
- FSM states:
  - IDLE: `start` → READ; clear the read address and beat counters.
  - READ: issue reads. After the read for address DEPTH-1 is issued → DRAIN.
  - DRAIN: wait for the last beat to handshake → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Credit rule:
  - `inflight` is 1 in the cycle after a read issues, else 0.
  - `pop` = `out_valid` & `out_ready`.
  - `rd_en` = (state==READ) & (fifo_count + inflight − pop < 2).
  - `rd_addr` = next read address, which increments on each issued read.
- FIFO write: at the edge ending a cycle with `inflight`=1, write {`rd_data`, address} into the FIFO.
- Under the credit rule the FIFO never overflows. An overflow is a design error; the bench asserts it never occurs.
- `out_valid` = (fifo_count ≠ 0).
  - `out_data`, `out_index` and `out_last` come from the FIFO head.
  - They must stay stable while `out_valid`=1 and `out_ready`=0.
- Beat counter:
  - Increments on `pop`.
  - The beat with `out_index`=DEPTH-1 moves the FSM from DRAIN to DONE.
- `start` in any state other than IDLE has no effect.
- A simultaneous FIFO push and pop in the same cycle leaves `fifo_count` unchanged, with correct ordering.
- Exactly DEPTH reads issue per frame, in ascending address order 0..DEPTH-1. No address is skipped or repeated.

## Timing
- Reset (asynchronous assertion, any state):
  - State returns to IDLE; FIFO, counters and `inflight` clear.
  - Outputs: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_last`=0, `out_index`=0, `out_data`=0.
  - A frame interrupted by reset is abandoned; after release, no beat of that frame appears.
- `start` sampled high at edge E0 in IDLE:
  - `busy`=1 and `rd_en`=1 with `rd_addr`=0 in the next cycle.
  - The memory samples this read at E1; `rd_data` is valid in the next cycle and is pushed at E2.
  - `out_valid`=1 after E2, so first-beat latency is 2 edges.
- With `out_ready` held high:
  - One beat per cycle, DEPTH consecutive beats; the last beat handshakes at E(DEPTH+2).
  - `done` pulses in the following cycle; `busy` falls with `done`.
  - `start` is accepted again in the cycle after `done`.
- With `out_ready` low:
  - At most 2 reads are outstanding in FIFO plus in flight.
  - `rd_en` stays 0 until a pop frees credit; no data is lost.

## Test plan
- Reset, then preload memory entry i = {16{i[31:0]}}; pulse `start` with `out_ready`=1.
  - Required: 16 consecutive beats, `out_index` 0..15 with matching data, `out_last` only on index 15, `out_valid` first high 2 edges after start, `done` a single cycle after the last beat.
- Same frame with `out_ready`=0 for 10 cycles from start.
  - Required: exactly 2 reads issued, `out_valid`=1 with index 0 stable throughout, then all 16 beats delivered in order with no loss or duplicates.
- Random `out_ready` (50%) over 3 back-to-back frames.
  - Required: the scoreboard matches 48 beats in order; the number of `rd_en` cycles per frame is exactly 16; the FIFO never overflows.
- `start` pulsed mid-frame, at beat 5.
  - Required: ignored, still exactly 16 beats, one `done`.
- `rst` asserted asynchronously mid-frame, at beat 7 with `out_valid`=1.
  - Required: all outputs go to their reset values immediately.
  - After release and a new `start`: a clean frame beginning at index 0.
- `out_ready` toggled every cycle during DRAIN.
  - Required: `out_last` beat held stable until accepted; `done` follows its handshake by exactly one cycle.

Source files
------------

// File: rtl/relu6_ram_reader_if.sv
// Handshake bundle for the layer-6 ReLU6 buffer reader: control, memory read port and output stream.
interface relu6_ram_reader_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 7
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    input  start,
    output busy, done,
    output rd_en, rd_addr,
    input  rd_data,
    output out_valid,
    input  out_ready,
    output out_data, out_index, out_last
  );

  modport slave (
    output start,
    input  busy, done,
    input  rd_en, rd_addr,
    output rd_data,
    input  out_valid,
    output out_ready,
    input  out_data, out_index, out_last
  );
endinterface

// File: rtl/relu6_ram_reader.sv
// Streams all DEPTH entries of the ReLU6 output buffer through a 2-entry FIFO, issuing
// reads only when FIFO space is guaranteed for the one-cycle-latency memory.
module relu6_ram_reader #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 512,
  parameter int ADDR_W = 7
) (
  input logic               clk,
  input logic               rst,
  relu6_ram_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] beat_cnt;
  logic              busy_q;
  logic              done_q;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;

  logic [DATA_W-1:0] fifo_data [2];
  logic [ADDR_W-1:0] fifo_idx  [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fifo_count;

  logic              head_valid;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        credit_used;

  assign head_valid  = (fifo_count != 2'd0);
  assign pop         = head_valid & bus.out_ready;
  assign push        = vld_p1;
  // Entries held plus the read in flight must stay below 2 after this edge's pop.
  assign credit_used = {1'b0, fifo_count} + {2'b00, vld_p1};
  assign issue       = (state == READ) && (credit_used < (3'd2 + {2'b00, pop}));

  // Stage 0 -> 1: read issued to memory, data returns next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr     <= '0;
      beat_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop)   beat_cnt <= beat_cnt + 1'b1;
      if (issue) addr     <= addr + 1'b1;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= READ;
            addr     <= '0;
            beat_cnt <= '0;
            busy_q   <= 1'b1;
          end
        end
        READ: begin
          if (issue && (addr == LAST)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && (beat_cnt == LAST)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 -> FIFO: returned data is written with the address it came from
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      vld_p1 <= issue;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    addr_p1 <= addr;
    if (push) begin
      fifo_data[wr_ptr] <= bus.rd_data;
      fifo_idx[wr_ptr]  <= addr_p1;
    end
  end

  // FIFO storage is not reset, so the head is masked while empty.
  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_valid ? fifo_data[rd_ptr] : '0;
  assign bus.out_index = head_valid ? fifo_idx[rd_ptr]  : '0;
  assign bus.out_last  = head_valid && (fifo_idx[rd_ptr] == LAST);
  assign bus.rd_en     = issue;
  assign bus.rd_addr   = addr;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_relu6_ram_reader.sv
// Bench for relu6_ram_reader: memory model, port monitor and a frame-level reference model.
module tb_relu6_ram_reader;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  relu6_ram_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  relu6_ram_reader #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[3:0]];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic check(input bit ok, input string name,
                       input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] data;
    int                idx;
    bit                last;
  } beat_t;

  beat_t             pops[$];
  int                rd_addrs[$];
  int                issued, popped, done_cnt, done_cyc, last_pop_cyc;
  bit                hold_prev;
  logic [DATA_W-1:0] hold_data;
  int                hold_idx;
  bit                hold_last;
  beat_t             mon_beat;

  task automatic clear_mon();
    pops.delete();
    rd_addrs.delete();
    issued = 0; popped = 0; done_cnt = 0;
    done_cyc = -1; last_pop_cyc = -100;
  endtask

  // Port monitor, mid-cycle: records reads, accepted beats and done; checks hold and credit
  always @(negedge clk) begin
    if (!rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        check(bus.out_valid && bus.out_data == hold_data && int'(bus.out_index) == hold_idx &&
              bus.out_last == hold_last, "hold_stable", bus.out_index, hold_idx);
      if (bus.rd_en) begin
        rd_addrs.push_back(int'(bus.rd_addr));
        issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        mon_beat.data = bus.out_data;
        mon_beat.idx  = int'(bus.out_index);
        mon_beat.last = bus.out_last;
        pops.push_back(mon_beat);
        popped++;
        if (bus.out_last) last_pop_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      check(issued - popped <= 2, "fifo_overflow", issued - popped, 2);
      hold_prev = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
      hold_idx  = int'(bus.out_index);
      hold_last = bus.out_last;
    end
  end

  task automatic fill_mem(input bit rnd);
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = i;
      mem[i] = {16{w}};
      if (rnd) for (int k = 0; k < 16; k++) mem[i][k*32 +: 32] = $urandom();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(bus.busy == 1'b0 && bus.done == 1'b0, {name, "_busy_done"}, {bus.busy, bus.done}, 0);
    check(bus.rd_en == 1'b0 && bus.rd_addr == '0, {name, "_rd"}, {bus.rd_en, bus.rd_addr}, 0);
    check(bus.out_valid == 1'b0 && bus.out_last == 1'b0 && bus.out_index == '0,
          {name, "_out_ctl"}, {bus.out_valid, bus.out_last, bus.out_index}, 0);
    check(bus.out_data == '0, {name, "_out_data"}, bus.out_data, 0);
  endtask

  // Frame runner: mode 0 ready high, 1 stall then high, 2 random, 3 toggle, 4 ready high + start at beat 5
  task automatic run_frame(input string name, input int mode, input int stall,
                           input int exp_beats, input int exp_done);
    int n;
    bit seen;
    int first_valid;
    bit ok;
    clear_mon();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check(bus.busy == 1'b1, {name, "_busy"}, bus.busy, 1);
    check(bus.rd_en == 1'b1 && bus.rd_addr == '0, {name, "_first_rd"}, {bus.rd_en, bus.rd_addr}, 8'h80);
    n = 0; seen = 0; first_valid = -1;
    while (!seen && n < 400) begin
      if (first_valid < 0 && bus.out_valid) first_valid = n;
      if (mode == 1 && n == stall) begin
        check(rd_addrs.size() == 2, {name, "_stall_reads"}, rd_addrs.size(), 2);
        check(bus.out_valid && bus.out_index == '0, {name, "_stall_head"}, {bus.out_valid, bus.out_index}, 8'h80);
      end
      case (mode)
        1:       bus.out_ready = (n >= stall);
        2:       bus.out_ready = ($urandom_range(0, 1) == 1);
        3:       bus.out_ready = ((n % 2) == 1);
        default: bus.out_ready = 1'b1;
      endcase
      bus.start = (mode == 4 && pops.size() == 5);
      @(posedge clk); #1;
      n++;
      if (bus.done) seen = 1;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(seen, {name, "_done_timeout"}, seen, 1);
    check(first_valid == 2, {name, "_first_valid"}, first_valid, 2);
    if (exp_done >= 0) check(n == exp_done, {name, "_done_latency"}, n, exp_done);
    check(pops.size() == exp_beats, {name, "_beats"}, pops.size(), exp_beats);
    for (int i = 0; i < pops.size() && i < exp_beats; i++)
      check(pops[i].data == mem[i] && pops[i].idx == i && pops[i].last == (i == DEPTH - 1),
            {name, "_beat"}, pops[i].idx, i);
    ok = (rd_addrs.size() == DEPTH);
    for (int i = 0; i < rd_addrs.size(); i++) if (rd_addrs[i] != i) ok = 0;
    check(ok, {name, "_read_order"}, rd_addrs.size(), DEPTH);
    check(done_cnt == 1, {name, "_done_count"}, done_cnt, 1);
    check(done_cyc == last_pop_cyc + 1, {name, "_done_after_last"}, done_cyc - last_pop_cyc, 1);
    check(bus.busy == 1'b0, {name, "_busy_end"}, bus.busy, 0);
  endtask

  typedef struct {
    string name;
    int    mode;
    int    stall;
    bit    rnd_mem;
    int    exp_beats;
    int    exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    vecs[0] = '{"ready_hi",  0, 0,  0, DEPTH, DEPTH + 2};
    vecs[1] = '{"stall10",   1, 10, 0, DEPTH, -1};
    vecs[2] = '{"rand_f1",   2, 0,  1, DEPTH, -1};
    vecs[3] = '{"rand_f2",   2, 0,  1, DEPTH, -1};
    vecs[4] = '{"rand_f3",   2, 0,  1, DEPTH, -1};
    vecs[5] = '{"mid_start", 4, 0,  0, DEPTH, DEPTH + 2};
    vecs[6] = '{"toggle",    3, 0,  1, DEPTH, -1};

    rst = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      fill_mem(vecs[v].rnd_mem);
      run_frame(vecs[v].name, vecs[v].mode, vecs[v].stall, vecs[v].exp_beats, vecs[v].exp_done);
    end

    // Asynchronous reset while beat 7 is waiting at the head
    fill_mem(0);
    clear_mon();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (pops.size() < 7 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    bus.out_ready = 1'b0;
    check(pops.size() == 7, "pre_reset_beats", pops.size(), 7);
    check(bus.out_valid && bus.out_index == 7'd7, "pre_reset_head", {bus.out_valid, bus.out_index}, 8'h87);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    clear_mon();
    @(negedge clk) rst = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check(pops.size() == 0 && rd_addrs.size() == 0, "abandoned_frame", pops.size() + rd_addrs.size(), 0);
    run_frame("after_rst", 0, 0, DEPTH, DEPTH + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
